// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, keyboard command and
// response bytes, and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_TX_IDLE,
    ST_TX_RTS,
    ST_TX_START,
    ST_TX_DATA,
    ST_TX_ACK,
    ST_TX_WAIT_IDLE
  } tx_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  localparam int WDOG_W = 20;

  // PS/2 frames carry odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Eight-sample debounce filter for the raw PS/2 clock line with a registered
// one-cycle pulse on each filtered falling edge.
module ps2_clk_filter (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_in,
  output logic ps2c_filt,
  output logic fall
);

  logic [7:0] taps_reg;
  logic [7:0] taps_next;
  logic       filt_next;

  // Decide on the post-shift window so the cleared taps after reset never
  // read as "eight zeros" and fake a falling edge.
  assign taps_next = {ps2c_in, taps_reg[7:1]};

  always_comb begin
    filt_next = ps2c_filt;
    if (taps_next == 8'hFF)
      filt_next = 1'b1;
    else if (taps_next == 8'h00)
      filt_next = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taps_reg  <= 8'h00;
      ps2c_filt <= 1'b1;
      fall      <= 1'b0;
    end else begin
      taps_reg  <= taps_next;
      ps2c_filt <= filt_next;
      fall      <= ps2c_filt & ~filt_next;
    end
  end

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, eleven device-clocked
// bits (start, data, parity, stop, ack) and a watchdog-guarded completion.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err_tick
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0]  INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0]  INH_PRE   = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX  = '1;

  tx_state_t         state;
  logic [INH_W-1:0]  inh_cnt;
  logic [WDOG_W-1:0] wdog;
  logic [8:0]        sr;
  logic [3:0]        n;
  logic              ack_ok;
  logic [1:0]        d_sync_reg;
  logic              d_sync;
  logic              clk_filt;
  logic              clk_fall;
  logic              active;
  logic              timeout;

  ps2_clk_filter u_clk_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2c_in   (ps2c_in),
    .ps2c_filt (clk_filt),
    .fall      (clk_fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      d_sync_reg <= 2'b11;
    else
      d_sync_reg <= {d_sync_reg[0], ps2d_in};
  end

  assign d_sync = d_sync_reg[1];

  assign active = (state == ST_TX_START) || (state == ST_TX_DATA) ||
                  (state == ST_TX_ACK)   || (state == ST_TX_WAIT_IDLE);

  // Fires on the TIMEOUT_CYCLES-th cycle without a device clock edge, so the
  // error tick lands exactly TIMEOUT_CYCLES cycles after the last edge.
  assign timeout = active && (wdog == WDOG_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_TX_IDLE;
      inh_cnt      <= '0;
      wdog         <= '0;
      sr           <= '0;
      n            <= '0;
      ack_ok       <= 1'b0;
      ps2c_oe      <= 1'b0;
      ps2d_oe      <= 1'b0;
      tx_idle      <= 1'b1;
      tx_done_tick <= 1'b0;
      tx_err_tick  <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      tx_err_tick  <= 1'b0;

      if (active) begin
        if (clk_fall)
          wdog <= '0;
        else if (wdog != WDOG_MAX)
          wdog <= wdog + 1'b1;
      end

      if (timeout) begin
        ps2c_oe     <= 1'b0;
        ps2d_oe     <= 1'b0;
        tx_err_tick <= 1'b1;
        tx_idle     <= 1'b1;
        state       <= ST_TX_IDLE;
      end else begin
        case (state)
          ST_TX_IDLE: begin
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b0;
            if (wr_ps2) begin
              sr      <= {odd_parity(din), din};
              inh_cnt <= '0;
              ps2c_oe <= 1'b1;
              tx_idle <= 1'b0;
              state   <= ST_TX_RTS;
            end
          end

          ST_TX_RTS: begin
            inh_cnt <= inh_cnt + 1'b1;
            if (inh_cnt == INH_LAST) begin
              ps2c_oe <= 1'b0;
              ps2d_oe <= 1'b1;
              n       <= '0;
              wdog    <= '0;
              state   <= ST_TX_START;
            end else if (inh_cnt == INH_PRE) begin
              ps2d_oe <= 1'b1;
            end
          end

          ST_TX_START: begin
            if (clk_fall) begin
              ps2d_oe <= ~sr[0];
              sr      <= {1'b0, sr[8:1]};
              n       <= 4'd1;
              state   <= ST_TX_DATA;
            end
          end

          ST_TX_DATA: begin
            if (clk_fall) begin
              n <= n + 1'b1;
              if (n == 4'd9) begin
                ps2d_oe <= 1'b0;
                state   <= ST_TX_ACK;
              end else begin
                ps2d_oe <= ~sr[0];
                sr      <= {1'b0, sr[8:1]};
              end
            end
          end

          ST_TX_ACK: begin
            if (clk_fall) begin
              ack_ok <= ~d_sync;
              state  <= ST_TX_WAIT_IDLE;
            end
          end

          ST_TX_WAIT_IDLE: begin
            if (clk_filt && d_sync) begin
              tx_done_tick <= ack_ok;
              tx_err_tick  <= ~ack_ok;
              tx_idle      <= 1'b1;
              state        <= ST_TX_IDLE;
            end
          end

          default: begin
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b0;
            tx_idle <= 1'b1;
            state   <= ST_TX_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a PS/2 keyboard model clocks frames out of the host and
// every observed frame is compared against the byte-level framing rules.
module tb_ps2_tx;

  localparam int INHIBIT = 20;
  localparam int TIMEOUT = 500;
  localparam int HALF    = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       ps2c_oe;
  logic       ps2d_oe;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       tx_err_tick;

  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int passed = 0;
  int total = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  // Open-drain wired-AND of host and device on both lines.
  assign ps2c_in = ~(ps2c_oe | dev_clk_low);
  assign ps2d_in = ~(ps2d_oe | dev_data_low);

  ps2_tx #(
    .INHIBIT_CYCLES (INHIBIT),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .ps2c_in      (ps2c_in),
    .ps2d_in      (ps2d_in),
    .ps2c_oe      (ps2c_oe),
    .ps2d_oe      (ps2d_oe),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .tx_err_tick  (tx_err_tick)
  );

  always @(negedge clk) begin
    if (tx_done_tick) done_cnt <= done_cnt + 1;
    if (tx_err_tick) err_cnt <= err_cnt + 1;
    if (tx_done_tick && tx_err_tick) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference framing: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Called on a falling clock edge; returns on the edge after acceptance.
  task automatic host_send(input logic [7:0] b);
    wr_ps2 = 1'b1;
    din    = b;
    @(negedge clk);
    wr_ps2 = 1'b0;
    din    = 8'($urandom);
    chk("start_latency_c_oe", int'(ps2c_oe), 1);
    chk("start_busy_idle", int'(tx_idle), 0);
  endtask

  // Device model: waits out request-to-send, then drives up to max_falls
  // clock pulses, sampling the data line at the end of each high phase.
  task automatic device_frame(input bit ack, input int max_falls, input bit poke,
                              output logic [10:0] bits, output int rts_cycles,
                              output int rts_d, output bit released);
    int guard;
    bits       = '0;
    rts_cycles = 0;
    rts_d      = 0;
    guard      = 0;
    while (ps2c_oe && guard < 200) begin
      rts_cycles++;
      if (ps2d_oe) rts_d++;
      @(negedge clk);
      guard++;
    end
    released = !ps2c_oe && ps2d_oe;
    if (!released || max_falls == 0) return;
    for (int k = 0; k < 11 && k < max_falls; k++) begin
      repeat (HALF) @(negedge clk);
      bits[k] = ps2d_in;
      if (k == 10 && ack) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      for (int c = 0; c < HALF; c++) begin
        if (poke && k == 3 && c == 10) begin
          wr_ps2 = 1'b1;
          din    = 8'h55;
        end else if (c == 11) begin
          wr_ps2 = 1'b0;
        end
        @(negedge clk);
      end
      dev_clk_low = 1'b0;
    end
    if (max_falls >= 11) begin
      repeat (HALF) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input bit ack,
                           input bit poke, input int exp_done, input int exp_err,
                           input int exp_par);
    logic [10:0] bits;
    logic [10:0] expected;
    int rts, rtsd, d0, e0, guard;
    bit rel;
    d0 = done_cnt;
    e0 = err_cnt;
    host_send(b);
    device_frame(ack, 11, poke, bits, rts, rtsd, rel);
    guard = 0;
    while (done_cnt == d0 && err_cnt == e0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (20) @(negedge clk);
    expected = model_frame(b);
    chk({tag, "_release"}, int'(rel), 1);
    chk({tag, "_rts_cycles"}, rts, INHIBIT);
    chk({tag, "_rts_data_cycles"}, rtsd, 1);
    chk({tag, "_frame_bits"}, int'(bits), int'(expected));
    if (exp_par >= 0) chk({tag, "_parity"}, int'(bits[9]), exp_par);
    chk({tag, "_done_ticks"}, done_cnt - d0, exp_done);
    chk({tag, "_err_ticks"}, err_cnt - e0, exp_err);
    chk({tag, "_idle_after"}, int'(tx_idle), 1);
    chk({tag, "_oe_after"}, int'({ps2c_oe, ps2d_oe}), 0);
    $display("frame %s din=%02h ack=%0d bits=%011b exp=%011b done=%0d err=%0d",
             tag, b, ack, bits, expected, done_cnt - d0, err_cnt - e0);
  endtask

  typedef struct {
    logic [7:0] din;
    bit         ack;
    int         exp_par;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [10:0] bits;
    int rts, rtsd, d0, e0, n;
    bit rel;
    logic [7:0] b;
    bit ack;

    vecs[0] = '{8'hED, 1'b1, 1, 1, 0};
    vecs[1] = '{8'h01, 1'b1, 0, 1, 0};
    vecs[2] = '{8'h00, 1'b1, 1, 1, 0};
    vecs[3] = '{8'hFF, 1'b1, 1, 1, 0};
    vecs[4] = '{8'hED, 1'b0, 1, 0, 1};
    vecs[5] = '{8'hF4, 1'b0, 0, 0, 1};

    repeat (3) @(negedge clk);
    chk("reset_idle", int'(tx_idle), 1);
    chk("reset_oe", int'({ps2c_oe, ps2d_oe}), 0);
    chk("reset_ticks", int'({tx_done_tick, tx_err_tick}), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].din, vecs[i].ack, 1'b0,
                vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_par);

    for (int i = 0; i < 6; i++) begin
      b   = 8'($urandom);
      ack = 1'($urandom_range(0, 1));
      run_frame($sformatf("rand%0d", i), b, ack, 1'b0, ack ? 1 : 0, ack ? 0 : 1, -1);
    end

    // Device never clocks after the host releases the clock line.
    d0 = done_cnt;
    e0 = err_cnt;
    host_send(8'hF4);
    device_frame(1'b1, 0, 1'b0, bits, rts, rtsd, rel);
    chk("timeout_release", int'(rel), 1);
    n = 0;
    while (!tx_err_tick && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", n, TIMEOUT);
    chk("timeout_oe", int'({ps2c_oe, ps2d_oe}), 0);
    @(negedge clk);
    chk("timeout_idle_next", int'(tx_idle), 1);
    repeat (20) @(negedge clk);
    chk("timeout_err_ticks", err_cnt - e0, 1);
    chk("timeout_done_ticks", done_cnt - d0, 0);
    $display("frame timeout din=f4 latency=%0d err=%0d", n, err_cnt - e0);

    // Start request with a different byte while a frame is in flight.
    run_frame("busy", 8'hF4, 1'b1, 1'b1, 1, 0, 0);

    // Reset in the middle of the data bits.
    d0 = done_cnt;
    e0 = err_cnt;
    host_send(8'hED);
    device_frame(1'b1, 5, 1'b0, bits, rts, rtsd, rel);
    chk("midreset_data_driven", int'(ps2d_oe), 1);
    reset = 1'b1;
    #1;
    chk("midreset_async_oe", int'({ps2c_oe, ps2d_oe}), 0);
    chk("midreset_async_idle", int'(tx_idle), 1);
    repeat (5) @(negedge clk);
    chk("midreset_hold_oe", int'({ps2c_oe, ps2d_oe}), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("midreset_ticks", (done_cnt - d0) + (err_cnt - e0), 0);
    $display("frame midreset din=ed bits=%011b ticks=%0d", bits,
             (done_cnt - d0) + (err_cnt - e0));
    run_frame("after_reset", 8'hFF, 1'b1, 1'b0, 1, 0, 1);

    chk("tick_exclusive", both_cnt, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, such as 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset).
- Sits beside ps2_rx inside keyboard, on the same 50 MHz clock.
- Drives the open-drain PS/2 clock and data lines through active-high pull-low enables. The top level builds the tristate buffers.
- Reports completion with a one-cycle tick and flags a missing device ack or a timeout as an error.

Parameters:
- INHIBIT_CYCLES, 6000: cycles the host holds the clock low for request-to-send (120 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum cycles between device clock falling edges before abort (15 ms at 50 MHz).

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- wr_ps2  in  1  start request, sampled only in IDLE.
- din  in  8  byte to send, latched when the start is accepted.
- ps2c_in  in  1  raw PS/2 clock line.
- ps2d_in  in  1  raw PS/2 data line.
- ps2c_oe  out  1  1 = pull the PS/2 clock low.
- ps2d_oe  out  1  1 = pull the PS/2 data low.
- tx_idle  out  1  1 in IDLE; the top uses it as rx_en for ps2_rx.
- tx_done_tick  out  1  one-cycle pulse: frame sent and acked.
- tx_err_tick  out  1  one-cycle pulse: no ack or timeout.

Behaviour:
- Reset (asynchronous):
  - state=IDLE, ps2c_oe=0, ps2d_oe=0, tx_idle=1, both ticks 0.
  - Counters, shift register and filter cleared; filter value=1.
  - Reset mid-frame releases both lines immediately.
- Clock filter: 8-sample shift-register filter on ps2c_in.
  - Filtered value goes to 1 when all eight samples are 1 and to 0 when all eight are 0; otherwise it holds.
  - fall = filtered value transitions 1→0.
- ps2d_in: two-flop synchroniser.
- Watchdog counter (20 bit): cleared on every fall and on entry to START. Saturating compare against TIMEOUT_CYCLES.
- Parity: odd, par = ~^din. Shift register sr[8:0] = {par, din}, loaded on accept.
- States:
  - IDLE:
    - Both oe=0.
    - On wr_ps2=1: latch din, load sr, clear the cycle counter, go to RTS.
  - RTS:
    - ps2c_oe=1.
    - ps2d_oe=0 for the first INHIBIT_CYCLES−1 cycles, then ps2d_oe=1 on the last cycle.
    - After exactly INHIBIT_CYCLES cycles with ps2c_oe=1, go to START.
    - fall is ignored in this state.
  - START:
    - ps2c_oe=0 (clock released), ps2d_oe=1 (start bit 0).
    - Edge counter n=0.
    - On fall: n=1, ps2d_oe=~sr[0], shift sr right, go to DATA.
  - DATA:
    - On each fall: n+1.
    - For n=2..9: ps2d_oe=~sr[0], then shift. Edges 1–8 carry d0..d7 LSB first; edge 9 carries parity.
    - On the 10th fall: ps2d_oe=0 (stop bit 1), go to ACK.
  - ACK:
    - On the 11th fall, sample the synchronised ps2d.
    - 0 → ack_ok=1, otherwise ack_ok=0. Go to WAIT_IDLE.
  - WAIT_IDLE:
    - Wait until filtered clock=1 and synchronised data=1.
    - Then pulse tx_done_tick if ack_ok, else tx_err_tick. Go to IDLE.
- Timeout: in START/DATA/ACK/WAIT_IDLE, if the watchdog reaches TIMEOUT_CYCLES:
  - ps2c_oe=0, ps2d_oe=0 in the same cycle;
  - pulse tx_err_tick;
  - go to IDLE.
- Error handling: no retry; the caller reissues the command.
- Busy: wr_ps2 outside IDLE is ignored, and din is not re-latched.
- Tick exclusivity: tx_done_tick and tx_err_tick are never both 1.
- tx_idle=1 only in IDLE. The frame the device clocks out is therefore never captured by ps2_rx.
- Outputs: ps2c_oe and ps2d_oe are registered and glitch-free.
- Start-to-line latency: ps2c_oe asserts one cycle after wr_ps2 is accepted.

Decomposition:
- Shared package ps2_pkg:
  - tx state enum {ST_TX_IDLE, ST_TX_RTS, ST_TX_START, ST_TX_DATA, ST_TX_ACK, ST_TX_WAIT_IDLE};
  - keyboard command constants CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF;
  - response constant RSP_ACK=8'hFA.
- One sub-module: ps2_clk_filter.
  - Contains the 8-tap filter plus fall detect.
  - Reused later by ps2_rx to remove its duplicated filter.

Test Plan (bench uses INHIBIT_CYCLES=20, TIMEOUT_CYCLES=500, and a device BFM generating a 10 kHz-scaled clock of 40-cycle half periods):
- Send 0xED, BFM acks:
  - BFM samples on its rising edges: 0,1,0,1,1,0,1,1,1,1,1 (start, d0..d7 LSB first, parity 1, stop 1).
  - Exactly one tx_done_tick; no tx_err_tick.
- Send 0x01 and 0x00:
  - Parity bits observed are 0 and 1 respectively.
  - ps2c_oe high for exactly 20 cycles before release.
- BFM omits the ack (data held high on the 11th clock):
  - tx_err_tick once, tx_done_tick never, both oe=0 afterwards.
- BFM never clocks after release:
  - tx_err_tick exactly 500 cycles after entry to START.
  - Lines released; tx_idle=1 on the following cycle.
- wr_ps2 pulsed with din=0x55 during DATA of a 0xF4 frame:
  - Frame bits still match 0xF4.
  - Exactly one tick.
- Assert reset after the 5th fall:
  - ps2c_oe=ps2d_oe=0 while reset is high, state=IDLE, no tick.
  - A new 0xFF send afterwards completes with tx_done_tick.
